// File: rtl/vc_io_pkg.sv
// Shared constants for the vc_io pad bank: pad drive modes and reset-sequencer states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vc_io_pkg;

    localparam logic PAD_PP = 1'b0;
    localparam logic PAD_OD = 1'b1;

    typedef enum logic {
        RS_HOLD = 1'b0,
        RS_RUN  = 1'b1
    } rs_state_t;

endpackage

// File: rtl/vc_io_pin.sv
// One pad: registered tristate driver, input synchroniser, glitch filter, edge detect, sticky irq pending.
// Latency: drive 1 cycle; input SYNC_STAGES+1 unfiltered, SYNC_STAGES+FILT_LEN filtered.
// Backpressure: none; pad and core sides are free-running levels.
module vc_io_pin
    import vc_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic drive_en,
    inout  wire  pad,
    input  logic core_out,
    input  logic core_oe,
    input  logic core_od,
    input  logic filt_en,
    output logic core_in,
    output logic rise,
    output logic fall,
    input  logic irq_re,
    input  logic irq_fe,
    input  logic irq_clr,
    output logic irq_pend,
    output logic irq_pend_nxt
);

    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic                   out_q;
    logic                   oe_q;
    logic                   pad_en;
    logic                   pad_val;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FC_W-1:0]        fc;
    logic                   filt_en_q;
    logic                   core_in_d;
    logic                   set;

    // drive_en also gates the enable combinationally so pads float the same cycle the core enters reset
    assign pad_val = (core_od == PAD_OD) ? 1'b0 : out_q;
    assign pad_en  = oe_q & drive_en & ((core_od == PAD_PP) | ~out_q);
    assign pad     = pad_en ? pad_val : 1'bz;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= 1'b0;
            oe_q      <= 1'b0;
            sync_q    <= '0;
            fc        <= '0;
            filt_en_q <= 1'b0;
            core_in   <= 1'b0;
            core_in_d <= 1'b0;
            irq_pend  <= 1'b0;
        end else begin
            out_q     <= core_out;
            oe_q      <= core_oe & drive_en;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pad};
            filt_en_q <= filt_en;
            core_in_d <= core_in;
            irq_pend  <= irq_pend_nxt;
            if (!filt_en) begin
                core_in <= s;
                fc      <= '0;
            end else if (!filt_en_q || (s == core_in)) begin
                fc <= '0;
            end else if (fc == FC_W'(FILT_LEN - 1)) begin
                core_in <= s;
                fc      <= '0;
            end else begin
                fc <= fc + 1'b1;
            end
        end
    end

    assign rise = core_in & ~core_in_d;
    assign fall = ~core_in & core_in_d;

    // a new edge beats a simultaneous write-one-to-clear
    assign set          = (rise & irq_re) | (fall & irq_fe);
    assign irq_pend_nxt = (irq_pend & ~irq_clr) | set;

endmodule

// File: rtl/vc_io_bank.sv
// Bidirectional pad bank with PLL-lock core-reset sequencer and per-pin interrupt logic.
// Latency: core_rst_n releases SYNC_STAGES+RST_HOLD cycles after pll_locked rises; irq 1 cycle after an edge.
// Backpressure: none; all interfaces are level-based.
module vc_io_bank
    import vc_io_pkg::*;
#(
    parameter int NPINS       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int RST_HOLD    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             core_rst_n,
    inout  wire  [NPINS-1:0] pad_io,
    input  logic [NPINS-1:0] core_out,
    input  logic [NPINS-1:0] core_oe,
    input  logic [NPINS-1:0] core_od,
    input  logic [NPINS-1:0] filt_en,
    output logic [NPINS-1:0] core_in,
    output logic [NPINS-1:0] rise,
    output logic [NPINS-1:0] fall,
    input  logic [NPINS-1:0] irq_re,
    input  logic [NPINS-1:0] irq_fe,
    input  logic [NPINS-1:0] irq_clr,
    output logic [NPINS-1:0] irq_pend,
    output logic             irq
);

    localparam int HC_W = $clog2(RST_HOLD + 1);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   locked_s;
    rs_state_t              state;
    logic [HC_W-1:0]        hc;
    logic [NPINS-1:0]       irq_pend_nxt;

    assign locked_s = lock_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync  <= '0;
            state      <= RS_HOLD;
            hc         <= '0;
            core_rst_n <= 1'b0;
            irq        <= 1'b0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
            irq       <= |irq_pend_nxt;
            case (state)
                RS_HOLD: begin
                    if (!locked_s) begin
                        hc <= '0;
                    end else if (hc == HC_W'(RST_HOLD - 1)) begin
                        state      <= RS_RUN;
                        core_rst_n <= 1'b1;
                        hc         <= '0;
                    end else begin
                        hc <= hc + 1'b1;
                    end
                end
                RS_RUN: begin
                    if (!locked_s) begin
                        state      <= RS_HOLD;
                        core_rst_n <= 1'b0;
                        hc         <= '0;
                    end
                end
                default: begin
                    state      <= RS_HOLD;
                    core_rst_n <= 1'b0;
                    hc         <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        vc_io_pin #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_pin (
            .clk          (clk),
            .rst_n        (rst_n),
            .drive_en     (core_rst_n),
            .pad          (pad_io[i]),
            .core_out     (core_out[i]),
            .core_oe      (core_oe[i]),
            .core_od      (core_od[i]),
            .filt_en      (filt_en[i]),
            .core_in      (core_in[i]),
            .rise         (rise[i]),
            .fall         (fall[i]),
            .irq_re       (irq_re[i]),
            .irq_fe       (irq_fe[i]),
            .irq_clr      (irq_clr[i]),
            .irq_pend     (irq_pend[i]),
            .irq_pend_nxt (irq_pend_nxt[i])
        );
    end

endmodule

// File: tb/tb_vc_io_bank.sv
// Directed bench for vc_io_bank: reset sequencing, drive modes, filter, edges, interrupts.
module tb_vc_io_bank;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       core_rst_n;
    tri   [7:0] pad_io;
    logic [7:0] core_out, core_oe, core_od, filt_en;
    logic [7:0] core_in, rise, fall;
    logic [7:0] irq_re, irq_fe, irq_clr, irq_pend;
    logic       irq;
    logic [7:0] tb_oe, tb_val;

    int checks;
    int failures;

    vc_io_bank #(
        .NPINS(8), .SYNC_STAGES(2), .FILT_LEN(4), .RST_HOLD(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .core_rst_n (core_rst_n),
        .pad_io     (pad_io),
        .core_out   (core_out),
        .core_oe    (core_oe),
        .core_od    (core_od),
        .filt_en    (filt_en),
        .core_in    (core_in),
        .rise       (rise),
        .fall       (fall),
        .irq_re     (irq_re),
        .irq_fe     (irq_fe),
        .irq_clr    (irq_clr),
        .irq_pend   (irq_pend),
        .irq        (irq)
    );

    // Board side: a pull-up on every pad plus an optional bench driver.
    for (genvar g = 0; g < 8; g++) begin : g_board
        assign pad_io[g] = tb_oe[g] ? tb_val[g] : 1'bz;
        pullup (pad_io[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int  n;
        logic hiz_ok;
        rst_n = 1'b0; pll_locked = 1'b1;
        core_out = 8'hFF; core_oe = 8'hFF; core_od = 8'h00; filt_en = 8'h00;
        irq_re = 8'h00; irq_fe = 8'h00; irq_clr = 8'h00;
        tb_oe = 8'hFF; tb_val = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
        checks++; if (core_in !== 8'h00) begin failures++; $display("FAIL reset_core_in got=%h exp=00", core_in); end
        checks++; if (irq_pend !== 8'h00 || irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%h/%b exp=00/0", irq_pend, irq); end
        rst_n = 1'b1;
        n = 0; hiz_ok = 1'b1;
        while (core_rst_n !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
            if (core_rst_n !== 1'b1 && pad_io !== 8'h00) hiz_ok = 1'b0;
        end
        checks++; if (n != 18) begin failures++; $display("FAIL reset_release_latency got=%0d exp=18", n); end
        checks++; if (!hiz_ok) begin failures++; $display("FAIL reset_pads_hiz got=driven exp=hiz"); end
        core_oe = 8'h00; core_out = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drive();
        tb_oe = 8'hFC; core_od = 8'h02;
        core_out[0] = 1'b0; core_oe[0] = 1'b1;
        #1;
        checks++; if (pad_io[0] !== 1'b1) begin failures++; $display("FAIL drive_pp_latency got=%b exp=1", pad_io[0]); end
        @(negedge clk);
        checks++; if (pad_io[0] !== 1'b0) begin failures++; $display("FAIL drive_pp_low got=%b exp=0", pad_io[0]); end
        core_out[0] = 1'b1;
        @(negedge clk);
        checks++; if (pad_io[0] !== 1'b1) begin failures++; $display("FAIL drive_pp_high got=%b exp=1", pad_io[0]); end
        tb_oe[1] = 1'b1; tb_val[1] = 1'b0; core_out[1] = 1'b1; core_oe[1] = 1'b1;
        @(negedge clk);
        checks++; if (pad_io[1] !== 1'b0) begin failures++; $display("FAIL drive_od_high_hiz got=%b exp=0", pad_io[1]); end
        tb_oe[1] = 1'b0; core_out[1] = 1'b0;
        @(negedge clk);
        checks++; if (pad_io[1] !== 1'b0) begin failures++; $display("FAIL drive_od_low got=%b exp=0", pad_io[1]); end
        core_oe[1] = 1'b0;
        @(negedge clk);
        checks++; if (pad_io[1] !== 1'b1) begin failures++; $display("FAIL drive_od_oe_off got=%b exp=1", pad_io[1]); end
        core_oe = 8'h00; core_out = 8'h00; core_od = 8'h00;
        @(negedge clk);
        tb_oe = 8'hFF; tb_val = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lock_loss();
        int n;
        core_out = 8'h00; core_oe = 8'hFF; tb_oe = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (pad_io !== 8'h00) begin failures++; $display("FAIL lock_run_drive got=%h exp=00", pad_io); end
        pll_locked = 1'b0;
        n = 0;
        while (core_rst_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 3) begin failures++; $display("FAIL lock_loss_latency got=%0d exp=3", n); end
        checks++; if (pad_io !== 8'hFF) begin failures++; $display("FAIL lock_loss_pads_hiz got=%h exp=ff", pad_io); end
        pll_locked = 1'b1;
        n = 0;
        while (core_rst_n !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (n != 18) begin failures++; $display("FAIL relock_latency got=%0d exp=18", n); end
        core_oe = 8'h00; tb_oe = 8'hFF; tb_val = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_unfiltered();
        tb_val[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) begin
                checks++; if (core_in[2] !== 1'b0) begin failures++; $display("FAIL unfilt_early got=%b exp=0", core_in[2]); end
            end
            if (k == 3) begin
                checks++; if (core_in[2] !== 1'b1 || rise[2] !== 1'b1) begin failures++; $display("FAIL unfilt_rise got=%b/%b exp=1/1", core_in[2], rise[2]); end
            end
            if (k == 4) begin
                checks++; if (rise[2] !== 1'b0) begin failures++; $display("FAIL unfilt_rise_width got=%b exp=0", rise[2]); end
            end
        end
        tb_val[2] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++; if (core_in[2] !== 1'b0 || fall[2] !== 1'b1) begin failures++; $display("FAIL unfilt_fall got=%b/%b exp=0/1", core_in[2], fall[2]); end
            end
        end
    endtask

    task automatic test_filter();
        logic seen;
        filt_en[3] = 1'b1;
        repeat (3) @(negedge clk);
        tb_val[3] = 1'b1; seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) tb_val[3] = 1'b0;
            if (core_in[3] !== 1'b0 || rise[3] !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL filt_reject_3 got=changed exp=steady"); end
        tb_val[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) tb_val[3] = 1'b0;
            if (k == 5) begin
                checks++; if (core_in[3] !== 1'b0) begin failures++; $display("FAIL filt_early got=%b exp=0", core_in[3]); end
            end
            if (k == 6) begin
                checks++; if (core_in[3] !== 1'b1 || rise[3] !== 1'b1) begin failures++; $display("FAIL filt_accept_4 got=%b/%b exp=1/1", core_in[3], rise[3]); end
            end
            if (k == 7) begin
                checks++; if (rise[3] !== 1'b0) begin failures++; $display("FAIL filt_rise_width got=%b exp=0", rise[3]); end
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_irq();
        checks++; if (irq_pend !== 8'h00 || irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%h/%b exp=00/0", irq_pend, irq); end
        irq_re[4] = 1'b1;
        tb_val[4] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++; if (irq_pend[4] !== 1'b0) begin failures++; $display("FAIL irq_pend_early got=%b exp=0", irq_pend[4]); end
            end
            if (k == 4) begin
                checks++; if (irq_pend[4] !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL irq_rise_set got=%b/%b exp=1/1", irq_pend[4], irq); end
            end
        end
        tb_val[4] = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (irq_pend[4] !== 1'b1) begin failures++; $display("FAIL irq_sticky got=%b exp=1", irq_pend[4]); end
        tb_val[4] = 1'b1;
        repeat (3) @(negedge clk);
        irq_clr[4] = 1'b1;
        @(negedge clk);
        irq_clr[4] = 1'b0;
        checks++; if (irq_pend[4] !== 1'b1) begin failures++; $display("FAIL irq_set_beats_clr got=%b exp=1", irq_pend[4]); end
        irq_clr[4] = 1'b1;
        @(negedge clk);
        irq_clr[4] = 1'b0;
        checks++; if (irq_pend[4] !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b/%b exp=0/0", irq_pend[4], irq); end
        irq_fe[5] = 1'b1;
        tb_val[5] = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (irq_pend[5] !== 1'b0) begin failures++; $display("FAIL irq_fe_ignores_rise got=%b exp=0", irq_pend[5]); end
        tb_val[5] = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (irq_pend[5] !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL irq_fall_set got=%b/%b exp=1/1", irq_pend[5], irq); end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (core_rst_n !== 1'b0 || irq_pend !== 8'h00 || irq !== 1'b0) begin failures++; $display("FAIL async_reset got=%b/%h/%b exp=0/00/0", core_rst_n, irq_pend, irq); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_drive();
        test_lock_loss();
        test_unfiltered();
        test_filter();
        test_irq();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
